// File: rtl/param_rotary_alu.sv
// Rotary-shaft driven ALU: operands and opcode are keyed in nibble by nibble on
// rising edges of rot_event, then one registered ADD/SUB/AND/XOR is executed.
module param_rotary_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rot_event,
  input  logic [3:0]       inp,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry_out,
  output logic             valid,
  output logic [2:0]       phase
);

  localparam int unsigned NIBS  = (WIDTH + 3) / 4;
  localparam int unsigned IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [2:0] {
    LOAD_A  = 3'b000,
    LOAD_B  = 3'b001,
    LOAD_OP = 3'b010,
    EXEC    = 3'b011,
    DONE    = 3'b100
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [WIDTH-1:0]   a, a_nxt, b, b_nxt;
  logic [1:0]         op, op_nxt;
  logic               prev_rot;
  logic [WIDTH-1:0]   result_nxt;
  logic               overflow_nxt, carry_nxt, valid_nxt;

  logic               step_c;
  logic               last_nib_c;
  logic [WIDTH-1:0]   b_eff_c;
  logic [SUM_W-1:0]   sum_c;
  logic [WIDTH-1:0]   alu_r_c;
  logic               alu_c_c, alu_v_c;

  assign step_c     = rot_event & ~prev_rot;
  assign last_nib_c = (idx == IDX_W'(NIBS - 1));
  assign phase      = state;

  // Bits of the top nibble beyond WIDTH simply have no destination, which
  // drops the unused high bits of inp on the last load step.
  function automatic logic [WIDTH-1:0] put_nib(input logic [WIDTH-1:0] cur,
                                               input logic [IDX_W-1:0] i,
                                               input logic [3:0]       n);
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    for (int k = 0; k < int'(WIDTH); k++) begin
      if (IDX_W'(k / 4) == i) nxt[k] = n[2'(k % 4)];
    end
    return nxt;
  endfunction

  // SUB is A + ~B + 1 so carry_out reads as "no borrow".
  always_comb begin
    b_eff_c = (op == 2'b01) ? ~b : b;
    sum_c   = {1'b0, a} + {1'b0, b_eff_c} + SUM_W'(op == 2'b01);
    alu_r_c = sum_c[WIDTH-1:0];
    alu_c_c = 1'b0;
    alu_v_c = 1'b0;
    case (op)
      2'b00: begin
        alu_c_c = sum_c[WIDTH];
        alu_v_c = (a[MSB] == b[MSB]) && (alu_r_c[MSB] != a[MSB]);
      end
      2'b01: begin
        alu_c_c = sum_c[WIDTH];
        alu_v_c = (a[MSB] != b[MSB]) && (alu_r_c[MSB] != a[MSB]);
      end
      2'b10:   alu_r_c = a & b;
      default: alu_r_c = a ^ b;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    a_nxt        = a;
    b_nxt        = b;
    op_nxt       = op;
    result_nxt   = result;
    overflow_nxt = overflow;
    carry_nxt    = carry_out;
    valid_nxt    = valid;
    case (state)
      LOAD_A: if (step_c) begin
        a_nxt = put_nib(a, idx, inp);
        if (last_nib_c) begin
          idx_nxt   = '0;
          state_nxt = LOAD_B;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      LOAD_B: if (step_c) begin
        b_nxt = put_nib(b, idx, inp);
        if (last_nib_c) begin
          idx_nxt   = '0;
          state_nxt = LOAD_OP;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      LOAD_OP: if (step_c) begin
        op_nxt    = inp[1:0];
        state_nxt = EXEC;
      end
      EXEC: begin
        result_nxt   = alu_r_c;
        overflow_nxt = alu_v_c;
        carry_nxt    = alu_c_c;
        valid_nxt    = 1'b1;
        state_nxt    = DONE;
      end
      DONE: if (step_c) begin
        valid_nxt = 1'b0;
        a_nxt     = '0;
        b_nxt     = '0;
        idx_nxt   = '0;
        state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  // prev_rot resets high so a level already present at release is not a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD_A;
      idx       <= '0;
      a         <= '0;
      b         <= '0;
      op        <= 2'b00;
      prev_rot  <= 1'b1;
      result    <= '0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      op        <= op_nxt;
      prev_rot  <= rot_event;
      result    <= result_nxt;
      overflow  <= overflow_nxt;
      carry_out <= carry_nxt;
      valid     <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_param_rotary_alu.sv
// Bench for param_rotary_alu: WIDTH=8 and WIDTH=7 instances driven by the same
// rotary steps, checked against a vector table and an arithmetic reference model.
module tb_param_rotary_alu;

  logic       clk;
  logic       rst;
  logic       rot_event;
  logic [3:0] inp;

  logic [7:0] res8;
  logic       ov8, co8, val8;
  logic [2:0] ph8;
  logic [6:0] res7;
  logic       ov7, co7, val7;
  logic [2:0] ph7;

  int checks   = 0;
  int failures = 0;
  bit in_done  = 1'b0;
  int prev8    = 0;
  int prev7    = 0;

  param_rotary_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .rot_event(rot_event), .inp(inp),
    .result(res8), .overflow(ov8), .carry_out(co8), .valid(val8), .phase(ph8)
  );

  param_rotary_alu #(.WIDTH(7)) dut7 (
    .clk(clk), .rst(rst), .rot_event(rot_event), .inp(inp),
    .result(res7), .overflow(ov7), .carry_out(co7), .valid(val7), .phase(ph7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] opn;
    logic [7:0] r8;
    logic       c8;
    logic       v8;
    logic [6:0] r7;
    logic       c7;
    logic       v7;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: operands are the loaded bytes truncated to w bits; flags from
  // signed/unsigned range arithmetic.
  function automatic void model(input int w, input logic [7:0] a8, input logic [7:0] b8,
                                input logic [3:0] opn, output int r, output int c, output int v);
    int mask, a, b, sa, sb, full, sres, hi, lo;
    mask = (1 << w) - 1;
    a    = int'(a8) & mask;
    b    = int'(b8) & mask;
    sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    hi   = (1 << (w - 1)) - 1;
    lo   = -(1 << (w - 1));
    c    = 0;
    v    = 0;
    case (opn & 4'h3)
      4'h0: begin
        full = a + b;
        r    = full & mask;
        c    = (full > mask) ? 1 : 0;
        sres = sa + sb;
        v    = (sres > hi || sres < lo) ? 1 : 0;
      end
      4'h1: begin
        r    = (a - b) & mask;
        c    = (a >= b) ? 1 : 0;
        sres = sa - sb;
        v    = (sres > hi || sres < lo) ? 1 : 0;
      end
      4'h2:    r = a & b;
      default: r = a ^ b;
    endcase
  endfunction

  // One rotary step: level high for 'hold' clk edges, then low.
  task automatic step(input logic [3:0] n, input int hold);
    @(negedge clk);
    inp       = n;
    rot_event = 1'b1;
    repeat (hold) @(negedge clk);
    rot_event = 1'b0;
    inp       = 4'($urandom);
  endtask

  task automatic chk_phase(input string nm, input logic [2:0] exp);
    chk({nm, "_ph8"}, 32'(ph8), 32'(exp));
    chk({nm, "_ph7"}, 32'(ph7), 32'(exp));
  endtask

  // Full operation from LOAD_A (or from DONE, via a clearing step first).
  // Returns at the negedge right after DONE is entered.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] opn);
    if (in_done) begin
      step(4'($urandom), 1);
      chk_phase("clear", 3'b000);
      chk("clear_valid", 32'({val8, val7}), 32'(0));
      chk("clear_hold_r8", 32'(res8), 32'(prev8));
      chk("clear_hold_r7", 32'(res7), 32'(prev7));
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    step(a[3:0], $urandom_range(1, 3));
    step(a[7:4], $urandom_range(1, 3));
    chk_phase("loadb", 3'b001);
    step(b[3:0], $urandom_range(1, 3));
    step(b[7:4], $urandom_range(1, 3));
    chk_phase("loadop", 3'b010);
    step(opn, 1);
    chk_phase("exec", 3'b011);
    chk("exec_valid", 32'({val8, val7}), 32'(0));
    chk("exec_hold_r8", 32'(res8), 32'(prev8));
    @(negedge clk);
    chk_phase("done", 3'b100);
    chk("done_valid", 32'({val8, val7}), 32'(3));
    in_done = 1'b1;
  endtask

  task automatic chk_out(input string nm, input int r8, input int c8, input int v8,
                         input int r7, input int c7, input int v7);
    chk({nm, "_r8"}, 32'(res8), 32'(r8));
    chk({nm, "_f8"}, 32'({co8, ov8}), 32'({c8[0], v8[0]}));
    chk({nm, "_r7"}, 32'(res7), 32'(r7));
    chk({nm, "_f7"}, 32'({co7, ov7}), 32'({c7[0], v7[0]}));
    prev8 = r8;
    prev7 = r7;
  endtask

  initial begin
    int r8, c8, v8, r7, c7, v7;
    logic [7:0] ra, rb;
    logic [3:0] ro;

    tbl[0] = '{8'h7F, 8'h01, 4'h0, 8'h80, 1'b0, 1'b1, 7'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h05, 8'h07, 4'h1, 8'hFE, 1'b0, 1'b0, 7'h7E, 1'b0, 1'b0};
    tbl[2] = '{8'h07, 8'h05, 4'h1, 8'h02, 1'b1, 1'b0, 7'h02, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 8'h01, 4'h3, 8'hFE, 1'b0, 1'b0, 7'h7E, 1'b0, 1'b0};
    tbl[5] = '{8'hF0, 8'h3C, 4'h2, 8'h30, 1'b0, 1'b0, 7'h30, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 8'h01, 4'h1, 8'h7F, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0};
    tbl[7] = '{8'hAA, 8'h0F, 4'hE, 8'h0A, 1'b0, 1'b0, 7'h0A, 1'b0, 1'b0};

    // Reset with rot_event already high: released level must not count.
    rst       = 1'b0;
    rot_event = 1'b1;
    inp       = 4'h5;
    #1 rst = 1'b1;
    #1;
    chk_phase("rst", 3'b000);
    chk("rst_out8", 32'({res8, co8, ov8, val8}), 32'(0));
    chk("rst_out7", 32'({res7, co7, ov7, val7}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_phase("rel_held", 3'b000);
    rot_event = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].opn);
      chk_out($sformatf("tbl%0d", i), int'(tbl[i].r8), int'(tbl[i].c8), int'(tbl[i].v8),
              int'(tbl[i].r7), int'(tbl[i].c7), int'(tbl[i].v7));
      repeat (2) @(negedge clk);
      chk("tbl_steady_r8", 32'(res8), 32'(tbl[i].r8));
    end

    // Step with inp=A from DONE must not load A; next op proves A restarted at 0.
    step(4'hA, 1);
    chk_phase("done_clr", 3'b000);
    chk("done_clr_valid", 32'({val8, val7}), 32'(0));
    in_done = 1'b0;
    run_op(8'h01, 8'h01, 4'h0);
    chk_out("after_clr", 8'h02, 0, 0, 7'h02, 0, 0);

    // Reset between 2nd and 3rd steps with rot_event held across release.
    step(4'hA, 1);
    in_done = 1'b0;
    step(4'h1, 1);
    step(4'h2, 1);
    chk_phase("mid_ld", 3'b001);
    @(negedge clk);
    rot_event = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk_phase("mid_rst", 3'b000);
    chk("mid_rst_out", 32'({res8, val8, res7, val7}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_phase("mid_rel_held", 3'b000);
    rot_event = 1'b0;
    prev8 = 0;
    prev7 = 0;
    run_op(8'h03, 8'h04, 4'h0);
    chk_out("post_rst", 8'h07, 0, 0, 7'h07, 0, 0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 4'($urandom);
      if (k % 5 == 0) rb = ra;
      run_op(ra, rb, ro);
      model(8, ra, rb, ro, r8, c8, v8);
      model(7, ra, rb, ro, r7, c7, v7);
      chk_out($sformatf("rnd%0d", k), r8, c8, v8, r7, c7, v7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
